// File: rtl/deser_lane_arbiter_pkg.sv
// deser_arb_pkg: shared types and helpers for the deserializer lane arbiter.
//   arb_state_t  : arbiter FSM state encoding
//   lane_bits(n) : width of a lane index, never less than one bit
package deser_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    function automatic int lane_bits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/deser_lane_arbiter_if.sv
// deser_arb_if: bundle between the serial lane front-ends and the arbiter.
//   i_req/i_wen/i_data  : per-lane request, bit strobe and serial bit
//   i_lock              : per-lane grant lock (only with DESER_ARB_LOCK_EN)
//   o_gnt/o_busy        : one-hot grant and grant-held flag
//   o_deser_wen/data    : muxed strobe and bit to the shared deserializer
//   o_lane_id/valid     : source lane tag, pulsed with the deserializer o_valid
// modport slave  : arbiter side
// modport master : lane / stimulus side
interface deser_arb_if
    import deser_arb_pkg::*;
#(
    parameter int NUM_LANES = 4
) ();
    localparam int LANE_BITS = lane_bits(NUM_LANES);

    logic [NUM_LANES-1:0] i_req;
    logic [NUM_LANES-1:0] i_wen;
    logic [NUM_LANES-1:0] i_data;
`ifdef DESER_ARB_LOCK_EN
    logic [NUM_LANES-1:0] i_lock;
`endif
    logic [NUM_LANES-1:0] o_gnt;
    logic                 o_deser_wen;
    logic                 o_deser_data;
    logic [LANE_BITS-1:0] o_lane_id;
    logic                 o_lane_valid;
    logic                 o_busy;

`ifdef DESER_ARB_LOCK_EN
    modport slave  (input  i_req, i_wen, i_data, i_lock,
                    output o_gnt, o_deser_wen, o_deser_data, o_lane_id, o_lane_valid, o_busy);
    modport master (output i_req, i_wen, i_data, i_lock,
                    input  o_gnt, o_deser_wen, o_deser_data, o_lane_id, o_lane_valid, o_busy);
`else
    modport slave  (input  i_req, i_wen, i_data,
                    output o_gnt, o_deser_wen, o_deser_data, o_lane_id, o_lane_valid, o_busy);
    modport master (output i_req, i_wen, i_data,
                    input  o_gnt, o_deser_wen, o_deser_data, o_lane_id, o_lane_valid, o_busy);
`endif

endinterface

// File: rtl/deser_lane_arbiter_rr_select.sv
// rr_select: combinational rotate-priority pick.
//   req      : per-lane request vector
//   ptr      : lane with highest priority this round
//   pick     : one-hot winner (zero when no request)
//   pick_idx : index of the winner
//   found    : any lane requesting
module rr_select #(
    parameter int NUM_LANES = 4,
    parameter int LANE_BITS = 2
) (
    input  logic [NUM_LANES-1:0] req,
    input  logic [LANE_BITS-1:0] ptr,
    output logic [NUM_LANES-1:0] pick,
    output logic [LANE_BITS-1:0] pick_idx,
    output logic                 found
);
    always_comb begin
        logic [LANE_BITS-1:0] cand;
        pick     = '0;
        pick_idx = '0;
        found    = 1'b0;
        cand     = '0;
        // Scan from ptr upward, wrapping; the first requester wins.
        for (int k = 0; k < NUM_LANES; k++) begin
            cand = LANE_BITS'((int'(ptr) + k) % NUM_LANES);
            if (!found && req[cand]) begin
                found      = 1'b1;
                pick[cand] = 1'b1;
                pick_idx   = cand;
            end
        end
    end
endmodule

// File: rtl/deser_lane_arbiter.sv
// deser_lane_arbiter: round-robin sharing of one deserializer among serial lanes.
// Ports:
//   i_clk : clock
//   i_rst : synchronous active-high reset
//   bus   : deser_arb_if.slave (requests, strobes, grant, muxed bit, lane tag)
// Optional: DESER_ARB_LOCK_EN adds bus.i_lock; a locked lane keeps its grant
// across word boundaries with no dead cycle.
//
// state     | meaning
// ARB_IDLE  | no grant; pick next requester from rr pointer
// ARB_GRANT | lane sel owns the deserializer until DATA_WIDTH bits accepted
module deser_lane_arbiter
    import deser_arb_pkg::*;
#(
    parameter int NUM_LANES  = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    deser_arb_if.slave bus
);
    localparam int LANE_BITS = lane_bits(NUM_LANES);
    localparam int CNT_W     = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0]     LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
    localparam logic [LANE_BITS-1:0] LAST_LANE = LANE_BITS'(NUM_LANES - 1);

    arb_state_t           state;
    logic [NUM_LANES-1:0] gnt;
    logic [NUM_LANES-1:0] pick;
    logic [LANE_BITS-1:0] sel;
    logic [LANE_BITS-1:0] ptr;
    logic [LANE_BITS-1:0] pick_idx;
    logic [LANE_BITS-1:0] lane_id;
    logic [CNT_W-1:0]     cnt;
    logic                 lane_valid;
    logic                 busy;
    logic                 pick_any;
    logic                 word_done;
    logic                 hold;

    rr_select #(
        .NUM_LANES (NUM_LANES),
        .LANE_BITS (LANE_BITS)
    ) u_rr_select (
        .req      (bus.i_req),
        .ptr      (ptr),
        .pick     (pick),
        .pick_idx (pick_idx),
        .found    (pick_any)
    );

    assign word_done = (state == ARB_GRANT) && bus.i_wen[sel] && (cnt == LAST_BIT);

`ifdef DESER_ARB_LOCK_EN
    assign hold = bus.i_lock[sel];
`else
    assign hold = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ARB_IDLE;
            gnt        <= '0;
            sel        <= '0;
            ptr        <= '0;
            cnt        <= '0;
            lane_id    <= '0;
            lane_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            lane_valid <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (pick_any) begin
                        state <= ARB_GRANT;
                        gnt   <= pick;
                        sel   <= pick_idx;
                        busy  <= 1'b1;
                    end
                end
                ARB_GRANT: begin
                    if (word_done) begin
                        cnt        <= '0;
                        lane_id    <= sel;
                        lane_valid <= 1'b1;
                        if (!hold) begin
                            state <= ARB_IDLE;
                            gnt   <= '0;
                            busy  <= 1'b0;
                            ptr   <= (sel == LAST_LANE) ? '0 : sel + 1'b1;
                        end
                    end else if (bus.i_wen[sel]) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // Zero-latency passthrough of the granted lane; forced quiet in reset
    // so the un-resettable deserializer never sees a stray strobe.
    assign bus.o_deser_wen  = (state == ARB_GRANT) && !i_rst && bus.i_wen[sel];
    assign bus.o_deser_data = (state == ARB_GRANT) && !i_rst && bus.i_data[sel];
    assign bus.o_gnt        = gnt;
    assign bus.o_lane_id    = lane_id;
    assign bus.o_lane_valid = lane_valid;
    assign bus.o_busy       = busy;

endmodule

// File: tb/tb_deser_lane_arbiter.sv
module tb_deser_lane_arbiter;

    localparam int NL = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NL-1:0] req = '0;
    logic [NL-1:0] wen = '0;
    logic [NL-1:0] data = '0;
    logic [NL-1:0] lock = '0;

    int total = 0;
    int passed = 0;

    deser_arb_if #(.NUM_LANES(NL)) bus ();

    assign bus.i_req  = req;
    assign bus.i_wen  = wen;
    assign bus.i_data = data;
`ifdef DESER_ARB_LOCK_EN
    assign bus.i_lock = lock;
`endif

    deser_lane_arbiter #(.NUM_LANES(NL), .DATA_WIDTH(DW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural deserializer: no reset, collects DW bits LSB-first.
    logic [7:0] d_sh = '0;
    logic [7:0] d_word = '0;
    logic       d_valid = 1'b0;
    int         d_cnt = 0;
    always @(posedge clk) begin
        d_valid <= 1'b0;
        if (bus.o_deser_wen) begin
            d_sh[d_cnt] <= bus.o_deser_data;
            if (d_cnt == DW - 1) begin
                d_word  <= {bus.o_deser_data, d_sh[6:0]};
                d_valid <= 1'b1;
                d_cnt   <= 0;
            end else begin
                d_cnt <= d_cnt + 1;
            end
        end
    end

    // Reference model: owner lane (-1 = none), bits collected, rr pointer.
    int         m_owner = -1;
    int         m_bits = 0;
    int         m_ptr = 0;
    int         m_id = 0;
    bit         m_valid = 1'b0;
    logic [7:0] m_acc = '0;
    logic [7:0] m_word = '0;

    task automatic model_step();
        bit keep;
        keep = 1'b0;
        if (rst) begin
            m_owner = -1; m_bits = 0; m_ptr = 0; m_id = 0; m_valid = 1'b0;
        end else begin
            m_valid = 1'b0;
            if (m_owner < 0) begin
                for (int k = 0; k < NL; k++) begin
                    int c;
                    c = (m_ptr + k) % NL;
                    if (m_owner < 0 && req[c]) m_owner = c;
                end
            end else if (wen[m_owner]) begin
                m_acc[m_bits] = data[m_owner];
                m_bits++;
                if (m_bits == DW) begin
                    m_valid = 1'b1;
                    m_id    = m_owner;
                    m_word  = m_acc;
                    m_bits  = 0;
`ifdef DESER_ARB_LOCK_EN
                    keep = lock[m_owner];
`endif
                    if (!keep) begin
                        m_ptr   = (m_owner + 1) % NL;
                        m_owner = -1;
                    end
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        else passed++;
    endtask

    logic [NL-1:0] seen_gnt;
    logic          seen_dwen;
    logic          seen_valid;
    logic [1:0]    seen_id;

    // One cycle: compare at negedge against the model, then advance at posedge.
    task automatic tick();
        logic [NL-1:0] e_gnt;
        logic e_wen, e_data;
        @(negedge clk);
        e_gnt = '0; e_wen = 1'b0; e_data = 1'b0;
        if (m_owner >= 0) begin
            e_gnt[m_owner] = 1'b1;
            e_wen  = wen[m_owner] && !rst;
            e_data = data[m_owner] && !rst;
        end
        check("gnt", 32'(bus.o_gnt), 32'(e_gnt));
        check("busy", 32'(bus.o_busy), 32'(m_owner >= 0));
        check("deser_wen", 32'(bus.o_deser_wen), 32'(e_wen));
        check("deser_data", 32'(bus.o_deser_data), 32'(e_data));
        check("lane_valid", 32'(bus.o_lane_valid), 32'(m_valid));
        check("lane_id", 32'(bus.o_lane_id), 32'(m_id));
        if (m_valid) begin
            check("deser_valid_sync", 32'(d_valid), 32'd1);
            check("deser_word", 32'(d_word), 32'(m_word));
        end
        seen_gnt   = bus.o_gnt;
        seen_dwen  = bus.o_deser_wen;
        seen_valid = bus.o_lane_valid;
        seen_id    = bus.o_lane_id;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; wen = '0; data = '0; lock = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // Reactive lanes: each pending lane requests, sends its word when granted.
    int got_ids[$];
    task automatic run_traffic(input logic [NL-1:0] pend_in, input int gap, input bit junk,
                               input bit drop, input int budget, input logic [7:0] w0,
                               input logic [7:0] w1, input logic [7:0] w2, input logic [7:0] w3);
        logic [7:0]    word [NL];
        int            sent [NL];
        logic [NL-1:0] pend;
        int            cyc;
        word[0] = w0; word[1] = w1; word[2] = w2; word[3] = w3;
        pend = pend_in; cyc = 0;
        for (int j = 0; j < NL; j++) sent[j] = 0;
        got_ids.delete();
        while (pend != '0 && cyc < budget) begin
            for (int j = 0; j < NL; j++) begin
                data[j] = junk ? 1'($urandom) : 1'b0;
                wen[j]  = junk ? 1'($urandom) : 1'b0;
                if (!pend[j]) begin
                    req[j] = 1'b0;
                end else if (bus.o_gnt[j]) begin
                    wen[j] = 1'b0;
                    if (sent[j] < DW && $urandom_range(99) >= gap) begin
                        wen[j]  = 1'b1;
                        data[j] = word[j][sent[j]];
                        sent[j]++;
                    end
                    if (drop && sent[j] >= 3) req[j] = 1'b0;
                end else if (sent[j] == DW) begin
                    pend[j] = 1'b0; req[j] = 1'b0; wen[j] = 1'b0;
                end else begin
                    req[j] = 1'b1; wen[j] = 1'b0;
                end
            end
            tick();
            if (seen_valid) begin
                got_ids.push_back(int'(seen_id));
                check("traffic_word", 32'(d_word), 32'(word[seen_id]));
            end
            cyc++;
        end
        if (pend != '0) check("traffic_timeout", 32'(pend), 32'd0);
        req = '0; wen = '0; data = '0;
        tick();
    endtask

    typedef struct {
        logic [NL-1:0] req, wen, data;
        logic [NL-1:0] gnt;
        logic          dwen, valid;
        logic [1:0]    id;
    } vec_t;

    vec_t tbl [11];

    initial begin
        logic [7:0] a5;
        int gcount, dcount, v1, v2;
        a5 = 8'hA5;
        for (int i = 0; i < 11; i++) begin
            tbl[i].req   = (i <= 8) ? 4'b0100 : 4'b0000;
            tbl[i].wen   = (i >= 1 && i <= 8) ? 4'b0100 : 4'b0000;
            tbl[i].data  = (i >= 1 && i <= 8) ? {1'b0, a5[i-1], 2'b00} : 4'b0000;
            tbl[i].gnt   = (i >= 1 && i <= 8) ? 4'b0100 : 4'b0000;
            tbl[i].dwen  = (i >= 1 && i <= 8);
            tbl[i].valid = (i == 9);
            tbl[i].id    = (i >= 9) ? 2'd2 : 2'd0;
        end

        @(posedge clk); model_step(); #1;
        do_reset();

        // Single lane 2 sends 0xA5.
        for (int i = 0; i < 11; i++) begin
            req = tbl[i].req; wen = tbl[i].wen; data = tbl[i].data;
            tick();
            check("tbl_gnt", 32'(seen_gnt), 32'(tbl[i].gnt));
            check("tbl_dwen", 32'(seen_dwen), 32'(tbl[i].dwen));
            check("tbl_valid", 32'(seen_valid), 32'(tbl[i].valid));
            check("tbl_id", 32'(seen_id), 32'(tbl[i].id));
            if (i == 9) check("tbl_word", 32'(d_word), 32'h0A5);
        end

        // Contention from reset: 0,1,3.
        do_reset();
        run_traffic(4'b1011, 0, 1'b0, 1'b0, 200, 8'h11, 8'h22, 8'h00, 8'h44);
        check("cont_count", 32'(got_ids.size()), 32'd3);
        if (got_ids.size() == 3) begin
            check("cont_id0", 32'(got_ids[0]), 32'd0);
            check("cont_id1", 32'(got_ids[1]), 32'd1);
            check("cont_id2", 32'(got_ids[2]), 32'd3);
        end

        // Gaps on lane 1 with req dropped after bit 3.
        req = 4'b0010; wen = '0; data = '0;
        tick();
        gcount = 0;
        for (int k = 0; k < 15; k++) begin
            wen[1]  = (k % 2 == 0);
            data[1] = (k % 2 == 0) ? 1'(8'h5B >> (k / 2)) : 1'b1;
            req[1]  = (k <= 6);
            tick();
            if (seen_gnt[1]) gcount++;
        end
        req = '0; wen = '0; data = '0;
        tick();
        if (seen_gnt[1]) gcount++;
        check("gap_valid", 32'(seen_valid), 32'd1);
        check("gap_word", 32'(d_word), 32'h05B);
        check("gap_hold_cycles", 32'(gcount), 32'd15);

        // Reset at word boundary with lane 3 requesting.
        rst = 1'b1; req = 4'b1000;
        tick();
        check("rst_gnt", 32'(bus.o_gnt), 32'd0);
        check("rst_busy", 32'(bus.o_busy), 32'd0);
        check("rst_valid", 32'(bus.o_lane_valid), 32'd0);
        check("rst_id", 32'(bus.o_lane_id), 32'd0);
        check("rst_dwen", 32'(bus.o_deser_wen), 32'd0);
        rst = 1'b0;
        tick();
        check("rst_then_gnt3", 32'(bus.o_gnt), 32'b1000);
        run_traffic(4'b1000, 0, 1'b0, 1'b0, 100, 8'h00, 8'h00, 8'h00, 8'hE7);

        // Lane 0 granted while lane 2 toggles without request.
        req = 4'b0001; wen = '0; data = '0;
        tick();
        dcount = 0;
        for (int k = 0; k < 8; k++) begin
            wen[0] = 1'b1; data[0] = 1'(8'h96 >> k);
            wen[2] = 1'b1; data[2] = k[0];
            tick();
            if (seen_dwen) dcount++;
        end
        req = '0; wen = '0; data = '0;
        tick();
        check("ign_valid", 32'(seen_valid), 32'd1);
        check("ign_id", 32'(seen_id), 32'd0);
        check("ign_word", 32'(d_word), 32'h096);
        check("ign_dwen_count", 32'(dcount), 32'd8);

        // Randomized rounds.
        for (int r = 0; r < 20; r++) begin
            run_traffic(4'($urandom_range(1, 15)), $urandom_range(0, 60), 1'b1,
                        1'($urandom), 400, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        end

`ifdef DESER_ARB_LOCK_EN
        do_reset();
        req = 4'b0011; lock = 4'b0001;
        tick();
        gcount = 0; v1 = -1; v2 = -1;
        for (int k = 0; k < 16; k++) begin
            wen = 4'b0001; data = {3'b000, 1'(16'hC33C >> k)};
            lock[0] = (k < 8); req[0] = (k < 15);
            tick();
            if (seen_gnt == 4'b0001) gcount++;
            if (seen_valid) begin v1 = k; check("lock_word0", 32'(d_word), 32'h03C); end
        end
        wen = '0; data = '0; lock = '0;
        tick();
        if (seen_valid) begin v2 = 16; check("lock_word1", 32'(d_word), 32'h0C3); end
        check("lock_gnt_cycles", 32'(gcount), 32'd16);
        check("lock_valid_gap", 32'(v2 - v1), 32'd8);
        tick();
        check("lock_then_lane1", 32'(seen_gnt), 32'b0010);
        run_traffic(4'b0010, 0, 1'b0, 1'b0, 100, 8'h00, 8'h81, 8'h00, 8'h00);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
